bcd_display_scan: RTL and testbench

Time-multiplexed 4-digit seven-segment driver that sits directly downstream of the stopwatch counter chain. It consumes the 16-bit packed BCD MM:SS value (minutes tens, minutes units, seconds tens, seconds units) and scans one digit at a time onto a common segment bus with per-digit anode enables. The input is latched once per frame so a count change mid-scan never shows a torn value.

---
 rtl/bcd_display_scan_pkg.sv | 48 ++++
 rtl/bcd_display_scan_if.sv | 14 +
 rtl/bcd_display_scan_seg_decode.sv | 9 +
 rtl/bcd_display_scan.sv | 102 ++++++++++
 tb/tb_bcd_display_scan.sv | 124 ++++++++++++
 5 files changed

// File: rtl/bcd_display_scan_pkg.sv
// Shared constants, segment encodings and the BCD-to-segment helper for the
// stopwatch display scanner.
package disp_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned DIGIT_W    = 4;

  typedef logic [6:0] seg_t;  // {g,f,e,d,c,b,a}, active-high

  localparam seg_t SEG_0    = 7'h3F;
  localparam seg_t SEG_1    = 7'h06;
  localparam seg_t SEG_2    = 7'h5B;
  localparam seg_t SEG_3    = 7'h4F;
  localparam seg_t SEG_4    = 7'h66;
  localparam seg_t SEG_5    = 7'h6D;
  localparam seg_t SEG_6    = 7'h7D;
  localparam seg_t SEG_7    = 7'h07;
  localparam seg_t SEG_8    = 7'h7F;
  localparam seg_t SEG_9    = 7'h6F;
  localparam seg_t SEG_DASH = 7'h40;

  // Digit scan order: seconds units first, minutes tens last.
  typedef enum logic [1:0] {
    DIG_SU = 2'd0,
    DIG_ST = 2'd1,
    DIG_MU = 2'd2,
    DIG_MT = 2'd3
  } digit_e;

  function automatic seg_t bcd_to_seg(input logic [DIGIT_W-1:0] d);
    seg_t s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_DASH;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bcd_display_scan_if.sv
// Display-side bus: packed BCD input plus blanking, scanned anode/segment outputs.
interface bcd_display_scan_if;
  import disp_pkg::*;

  logic [NUM_DIGITS*DIGIT_W-1:0] Q;
  logic                          BLANK;
  logic [NUM_DIGITS-1:0]         AN;
  seg_t                          SEG;
  logic                          DP;
  logic                          FRAME;

  modport master (output Q, BLANK, input AN, SEG, DP, FRAME);
  modport slave  (input Q, BLANK, output AN, SEG, DP, FRAME);
endinterface

// File: rtl/bcd_display_scan_seg_decode.sv
// Combinational BCD digit to seven-segment decoder; non-BCD codes show a dash.
module bcd_seg_decode
  import disp_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit_i,
  output seg_t               seg_o
);
  always_comb seg_o = bcd_to_seg(digit_i);
endmodule

// File: rtl/bcd_display_scan.sv
// Time-multiplexed 4-digit MM:SS seven-segment scanner with a per-frame input latch.
// Optional DP blinking is enabled by defining DISP_DP_BLINK_EN.
module bcd_display_scan
  import disp_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 4096,
  parameter bit          ACTIVE_LOW  = 1'b1
) (
  input  logic              clk,
  input  logic              RESET,
  bcd_display_scan_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
  localparam int unsigned LAT_W = NUM_DIGITS * DIGIT_W;

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  digit_e                idx_q, idx_d;
  logic [LAT_W-1:0]      latch_q, latch_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  seg_t                  seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic                  frame_q, frame_d;
  logic                  tc, frame_end;
  logic [DIGIT_W-1:0]    digit;
  logic [NUM_DIGITS-1:0] an_sel;
  logic                  dp_en;

  assign tc        = (cnt_q == CNT_W'(REFRESH_DIV - 1));
  assign frame_end = tc && (idx_q == DIG_MT);

  always_comb begin
    cnt_d   = tc ? '0 : cnt_q + 1'b1;
    idx_d   = tc ? digit_e'(idx_q + 2'd1) : idx_q;
    latch_d = frame_end ? bus.Q : latch_q;
    frame_d = frame_end;
  end

  always_comb begin
    digit  = '0;
    an_sel = '0;
    case (idx_q)
      DIG_SU: begin digit = latch_q[3:0];   an_sel = 4'b0001; end
      DIG_ST: begin digit = latch_q[7:4];   an_sel = 4'b0010; end
      DIG_MU: begin digit = latch_q[11:8];  an_sel = 4'b0100; end
      DIG_MT: begin
        digit  = latch_q[15:12];
        an_sel = (latch_q[15:12] == 4'd0) ? 4'b0000 : 4'b1000;
      end
      default: ;
    endcase
  end

  bcd_seg_decode u_dec (
    .digit_i (digit),
    .seg_o   (seg_d)
  );

`ifdef DISP_DP_BLINK_EN
  // Toggle whenever a frame reload brings a new seconds-units value.
  logic blink_q;
  always_ff @(posedge clk) begin
    if (RESET) begin
      blink_q <= 1'b0;
    end else if (frame_end && (bus.Q[3:0] != latch_q[3:0])) begin
      blink_q <= ~blink_q;
    end
  end
  assign dp_en = blink_q;
`else
  assign dp_en = 1'b1;
`endif

  always_comb begin
    an_d = bus.BLANK ? '0 : an_sel;
    dp_d = (idx_q == DIG_MU) && dp_en;
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      cnt_q   <= '0;
      idx_q   <= DIG_SU;
      latch_q <= '0;
      an_q    <= '0;
      seg_q   <= '0;
      dp_q    <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      latch_q <= latch_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      frame_q <= frame_d;
    end
  end

  assign bus.AN    = ACTIVE_LOW ? ~an_q  : an_q;
  assign bus.SEG   = ACTIVE_LOW ? ~seg_q : seg_q;
  assign bus.DP    = ACTIVE_LOW ? ~dp_q  : dp_q;
  assign bus.FRAME = frame_q;
endmodule

// File: tb/tb_bcd_display_scan.sv
// Self-checking bench for bcd_display_scan (REFRESH_DIV=4, active-high pins).
module tb_bcd_display_scan;
  localparam int unsigned R     = 4;
  localparam int unsigned FRAME = 4 * R;

  logic clk = 1'b0;
  logic RESET = 1'b1;
  always #5 clk = ~clk;

  bcd_display_scan_if bus ();

  bcd_display_scan #(.REFRESH_DIV(R), .ACTIVE_LOW(1'b0)) dut (
    .clk   (clk),
    .RESET (RESET),
    .bus   (bus)
  );

  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

  int unsigned tests = 0;
  int unsigned fails = 0;
  int unsigned cyc   = 0;       // cycles since reset release
  logic [15:0] m_latch = '0;    // value shown this frame
  logic        m_blink = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s @cyc %0d: observed %h, expected %h", tag, cyc, obs, exp);
    end
  endtask

  // Advance one clock and check all outputs against the frame-level model.
  task automatic step();
    int unsigned slot;
    logic [3:0]  dig;
    logic [3:0]  e_an;
    logic        e_dp, fend;
    logic [15:0] qs;
    slot = (cyc / R) % 4;
    dig  = 4'(m_latch >> (4 * slot));
    if (bus.BLANK || (slot == 3 && m_latch[15:12] == 4'd0)) e_an = 4'b0000;
    else e_an = 4'(1 << slot);
`ifdef DISP_DP_BLINK_EN
    e_dp = (slot == 2) && m_blink;
`else
    e_dp = (slot == 2);
`endif
    fend = (cyc % FRAME) == FRAME - 1;
    qs   = bus.Q;
    @(posedge clk); #1;
    if (fend) begin
      if (qs[3:0] != m_latch[3:0]) m_blink = ~m_blink;
      m_latch = qs;
    end
    cyc++;
    chk("AN",    32'(bus.AN),    32'(e_an));
    chk("SEG",   32'(bus.SEG),   32'(seg_tab[dig]));
    chk("DP",    32'(bus.DP),    32'(e_dp));
    chk("FRAME", 32'(bus.FRAME), 32'(fend));
  endtask

  task automatic run(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step();
  endtask

  // Step until the next cycle to execute has the requested frame phase.
  task automatic run_to(input int unsigned phase);
    for (int unsigned i = 0; i < FRAME && (cyc % FRAME) != phase; i++) step();
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    @(posedge clk); #1;
    chk("RST_AN",    32'(bus.AN),    32'h0);
    chk("RST_SEG",   32'(bus.SEG),   32'h0);
    chk("RST_DP",    32'(bus.DP),    32'h0);
    chk("RST_FRAME", 32'(bus.FRAME), 32'h0);
    cyc = 0; m_latch = '0; m_blink = 1'b0;
    RESET = 1'b0;
  endtask

  initial begin
    bus.Q = 16'h1020; bus.BLANK = 1'b0;
    #1;
    do_reset();
    // Held value: first frame shows cleared latch, then 10.20
    run(2 * FRAME);
    // Mid-frame change at digit 1 must wait for the frame boundary
    run_to(R + 1);
    bus.Q = 16'h1021;
    run(2 * FRAME);
    // Leading-zero blanking and dash decode
    bus.Q = 16'h0359; run(2 * FRAME);
    bus.Q = 16'h1A2F; run(2 * FRAME);
    // Blank burst mid-frame
    run_to(5);
    bus.BLANK = 1'b1; run(6);
    bus.BLANK = 1'b0; run(FRAME);
    // Reset while digit 2 is showing
    run_to(2 * R + 1);
    do_reset();
    run(2 * FRAME);
    // Seconds-units stepping across frames
    bus.Q = 16'h1020; run(FRAME);
    bus.Q = 16'h1021; run(FRAME);
    bus.Q = 16'h1022; run(FRAME);
    bus.Q = 16'h1022; run(FRAME);
    // Randomized values, change points and blanking
    for (int unsigned f = 0; f < 40; f++) begin
      for (int unsigned c = 0; c < FRAME; c++) begin
        if ($urandom_range(0, 7) == 0) bus.Q = 16'($urandom());
        bus.BLANK = ($urandom_range(0, 9) == 0);
        step();
      end
    end
    bus.BLANK = 1'b0;
    run(FRAME);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
